axi4_sram_wr_slave: RTL

//  AXI4 write-channel slave (AW/W/B) that terminates the axi4_intf write channels and drives a single-port SRAM write port.

---
 rtl/axi4_pkg.sv | 22 ++
 rtl/axi4_burst_addr_gen.sv | 52 +++++
 rtl/axi4_sram_wr_slave.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 types and constants for the SRAM slave blocks.
// Burst encodings, response codes, write-FSM states and the 4KB page size.
package axi4_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } wr_state_e;

    localparam int BOUNDARY_4KB = 4096;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational AXI burst address step and byte-lane mask.
// Ports: addr_i/size_i/len_i/burst_i -> next_addr_o, lane_mask_o (lanes of addr_i).
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic [ADDRESS_WIDTH-1:0]  addr_i,
    input  logic [2:0]                size_i,
    input  logic [7:0]                len_i,
    input  logic [1:0]                burst_i,
    output logic [ADDRESS_WIDTH-1:0]  next_addr_o,
    output logic [DATA_WIDTH/8-1:0]   lane_mask_o
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);

    logic [ADDRESS_WIDTH-1:0] step;
    logic [ADDRESS_WIDTH-1:0] aligned;
    logic [ADDRESS_WIDTH-1:0] wrap_len;
    logic [ADDRESS_WIDTH-1:0] lower;
    logic [ADDRESS_WIDTH-1:0] incr;
    int                       lo;
    int                       hi;

    always_comb begin
        step     = ONE << size_i;
        aligned  = addr_i & ~(step - ONE);
        wrap_len = (ADDRESS_WIDTH'(len_i) + ONE) << size_i;
        lower    = addr_i & ~(wrap_len - ONE);
        incr     = addr_i + step;

        next_addr_o = addr_i;
        case (burst_i)
            INCR:    next_addr_o = aligned + step;
            WRAP:    next_addr_o = (incr == lower + wrap_len) ? lower : incr;
            default: next_addr_o = addr_i;
        endcase

        // Active lanes run from the byte offset of the address up to the
        // end of the size-aligned container holding it.
        lo = int'(addr_i) & (NB - 1);
        hi = (int'(aligned) & (NB - 1)) + (1 << size_i);
        lane_mask_o = '0;
        for (int i = 0; i < NB; i++) begin
            lane_mask_o[i] = (i >= lo) && (i < hi);
        end
    end

endmodule

// File: rtl/axi4_sram_wr_slave.sv
// AXI4 write slave: accepts one AW burst, writes each W beat to a single-port
// SRAM, returns B. Ports: AXI AW/W/B channels, mem_* SRAM write port,
// four_4Kb_voilation pulse for INCR bursts crossing a 4KB page.
module axi4_sram_wr_slave
    import axi4_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ID_WIDTH-1:0]       awid,
    input  logic [ADDRESS_WIDTH-1:0]  awaddr,
    input  logic [7:0]                awlen,
    input  logic [2:0]                awsize,
    input  logic [1:0]                awburst,
    input  logic                      awlock,
    input  logic [2:0]                awprot,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [ID_WIDTH-1:0]       bid,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    output logic                      mem_we,
    output logic [ADDRESS_WIDTH-$clog2(DATA_WIDTH/8)-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
    output logic                      four_4Kb_voilation
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int MW  = ADDRESS_WIDTH - OFF;
    localparam logic [2:0] MAX_SIZE = 3'(OFF);
    localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);

    wr_state_e                 state_q;
    logic                      awready_q;
    logic                      wready_q;
    logic                      bvalid_q;
    logic [ID_WIDTH-1:0]       bid_q;
    logic [1:0]                bresp_q;
    logic                      mem_we_q;
    logic [MW-1:0]             mem_addr_q;
    logic [DATA_WIDTH-1:0]     mem_wdata_q;
    logic [NB-1:0]             mem_wstrb_q;
    logic                      four_q;

    logic [ID_WIDTH-1:0]       id_q;
    logic [ADDRESS_WIDTH-1:0]  addr_q;
    logic [7:0]                len_q;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;
    logic [7:0]                cnt_q;
    logic                      err_q;

    logic [ADDRESS_WIDTH-1:0]  addr_d;
    logic [NB-1:0]             lane_mask;
    logic [ADDRESS_WIDTH-1:0]  size_mask;
    logic [23:0]               burst_bytes;
    logic [23:0]               end_off;
    logic                      cross_4kb;
    logic                      bad_size;
    logic                      bad_wrap;
    logic                      aw_err;
    logic                      aw_hs;
    logic                      w_hs;
    logic                      last_by_cnt;
    logic                      w_end;
    logic                      len_mismatch;
    logic                      aw_sideband_unused;

    // Lock and protection are accepted but have no effect on an SRAM.
    assign aw_sideband_unused = ^{awlock, awprot};

    axi4_burst_addr_gen #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_addr_gen (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .next_addr_o (addr_d),
        .lane_mask_o (lane_mask)
    );

    always_comb begin
        // Page check works on the in-page offset, so a burst that ends
        // exactly on byte 0xFFF is still legal.
        burst_bytes = ({16'd0, awlen} + 24'd1) << awsize;
        end_off     = {12'd0, awaddr[11:0]} + burst_bytes - 24'd1;
        cross_4kb   = (awburst == INCR) && (end_off >= 24'(BOUNDARY_4KB));
        bad_size    = awsize > MAX_SIZE;
        size_mask   = (ONE << awsize) - ONE;
        bad_wrap    = (awburst == WRAP) &&
                      (!(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                       ((awaddr & size_mask) != '0));
        aw_err      = (awburst == 2'b11) || bad_size || bad_wrap || cross_4kb;

        aw_hs        = awvalid && awready_q;
        w_hs         = wvalid && wready_q;
        last_by_cnt  = cnt_q == len_q;
        // Whichever comes first closes the burst; disagreement is an error.
        w_end        = wlast || last_by_cnt;
        len_mismatch = wlast != last_by_cnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= RESP_OKAY;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            four_q      <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            four_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        id_q      <= awid;
                        addr_q    <= awaddr;
                        len_q     <= awlen;
                        size_q    <= awsize;
                        burst_q   <= awburst;
                        cnt_q     <= '0;
                        err_q     <= aw_err;
                        four_q    <= cross_4kb;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        state_q   <= DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        mem_we_q    <= !err_q;
                        mem_addr_q  <= addr_q[ADDRESS_WIDTH-1:OFF];
                        mem_wdata_q <= wdata;
                        mem_wstrb_q <= wstrb & lane_mask;
                        if (w_end) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= id_q;
                            bresp_q  <= (err_q || len_mismatch) ?
                                        RESP_SLVERR : RESP_OKAY;
                            state_q  <= RESP;
                        end else begin
                            cnt_q  <= cnt_q + 8'd1;
                            addr_q <= addr_d;
                        end
                    end
                end
                RESP: begin
                    if (bvalid_q && bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign awready            = awready_q;
    assign wready             = wready_q;
    assign bvalid             = bvalid_q;
    assign bid                = bid_q;
    assign bresp              = bresp_q;
    assign mem_we             = mem_we_q;
    assign mem_addr           = mem_addr_q;
    assign mem_wdata          = mem_wdata_q;
    assign mem_wstrb          = mem_wstrb_q;
    assign four_4Kb_voilation = four_q;

endmodule
